// File: rtl/sub_serial_if.sv
// -----------------------------------------------------------------------------
// sub_serial_if
// Handshake bundle for the serial subtractor.
//   Operand side : in_valid, in_ready, a (minuend), b (subtrahend)
//   Result side  : out_valid, out_ready, diff, borrow, overflow, zero
// Modports:
//   master - producer of operands / consumer of results (the surrounding
//            datapath or a testbench)
//   slave  - the subtractor itself
// -----------------------------------------------------------------------------
interface sub_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow, overflow, zero
   );
endinterface

// File: rtl/sub_serial.sv
// -----------------------------------------------------------------------------
// sub_serial
// Multi-cycle subtractor: diff = a - b computed as a + ~b + 1 with a DIGIT-bit
// adder slice and a registered carry, DIGIT bits per clock, LSB digit first.
// Parameters:
//   WIDTH - operand/result width
//   DIGIT - bits per cycle; must divide WIDTH (1, 2, 4, 8, 16 for WIDTH = 16)
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - sub_serial_if slave modport (operand and result handshakes)
// Flow: IDLE accepts operands, RUN spends WIDTH/DIGIT cycles on the digits,
// DONE holds the registered result until out_ready.
// -----------------------------------------------------------------------------
module sub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   sub_serial_if.slave  bus
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   // acc_q starts as the minuend and doubles as the result register: each RUN
   // cycle consumes its low digit and shifts the new sum digit in at the MSB
   // end, so after NDIG cycles it holds the full difference.
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] nb_q, nb_d;        // inverted subtrahend, shifted right
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Operand sign bits are kept aside because the shift registers lose them.
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   // DIGIT-bit full-adder slice; bit DIGIT is the carry out.
   logic [DIGIT:0]   slice_sum;
   logic [WIDTH-1:0] acc_shift;
   logic [WIDTH-1:0] nb_shift;

   assign slice_sum = {1'b0, acc_q[DIGIT-1:0]}
                    + {1'b0, nb_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};

   // With DIGIT == WIDTH there is nothing left to shift, so the slices that
   // would otherwise be empty are avoided.
   if (DIGIT == WIDTH) begin : g_single
      assign acc_shift = slice_sum[DIGIT-1:0];
      assign nb_shift  = '0;
   end else begin : g_multi
      assign acc_shift = {slice_sum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
      assign nb_shift  = {{DIGIT{1'b0}}, nb_q[WIDTH-1:DIGIT]};
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      nb_d        = nb_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      a_msb_d     = a_msb_q;
      b_msb_d     = b_msb_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               acc_d      = bus.a;
               nb_d       = ~bus.b;
               a_msb_d    = bus.a[WIDTH-1];
               b_msb_d    = bus.b[WIDTH-1];
               carry_d    = 1'b1;          // the +1 of two's complement
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end

         RUN: begin
            acc_d   = acc_shift;
            nb_d    = nb_shift;
            carry_d = slice_sum[DIGIT];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_DIGIT) begin
               diff_d      = acc_shift;
               // Final carry out of a + ~b + 1 is 1 exactly when a >= b.
               borrow_d    = ~slice_sum[DIGIT];
               overflow_d  = (a_msb_q != b_msb_q) && (acc_shift[WIDTH-1] != a_msb_q);
               zero_d      = (acc_shift == '0);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         nb_q        <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         nb_q        <= nb_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.diff      = diff_q;
   assign bus.borrow    = borrow_q;
   assign bus.overflow  = overflow_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_serial
// Drives three sub_serial instances (DIGIT = 1, 4, 16) with identical operands
// and compares their results and latencies with an arithmetic reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sub_serial;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sub_serial_if #(.WIDTH(16)) if1 ();
   sub_serial_if #(.WIDTH(16)) if4 ();
   sub_serial_if #(.WIDTH(16)) if16 ();

   sub_serial #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   sub_serial #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   sub_serial #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic.
   function automatic logic [15:0] mdl_diff(input logic [15:0] av, input logic [15:0] bv);
      int d;
      d = int'(av) - int'(bv);
      return d[15:0];
   endfunction

   // {borrow, overflow, zero}
   function automatic logic [2:0] mdl_flags(input logic [15:0] av, input logic [15:0] bv);
      int  sd;
      logic bo, ov, z;
      sd = int'($signed(av)) - int'($signed(bv));
      bo = (av < bv);
      ov = (sd > 32767) || (sd < -32768);
      z  = (mdl_diff(av, bv) == 16'h0000);
      return {bo, ov, z};
   endfunction

   task automatic set_in(input logic v, input logic [15:0] av, input logic [15:0] bv);
      if1.in_valid = v;  if1.a = av;  if1.b = bv;
      if4.in_valid = v;  if4.a = av;  if4.b = bv;
      if16.in_valid = v; if16.a = av; if16.b = bv;
   endtask

   task automatic set_ordy(input logic v);
      if1.out_ready  = v;
      if4.out_ready  = v;
      if16.out_ready = v;
   endtask

   task automatic chk_out(input string tag, input logic [15:0] d, input logic bo,
                          input logic ov, input logic z,
                          input logic [15:0] av, input logic [15:0] bv);
      chk({tag, "_diff"},  32'(d),            32'(mdl_diff(av, bv)));
      chk({tag, "_flags"}, 32'({bo, ov, z}),  32'(mdl_flags(av, bv)));
   endtask

   task automatic chk_rst(input string tag, input logic ir, input logic ov_valid,
                          input logic [15:0] d, input logic bo, input logic ov,
                          input logic z);
      chk({tag, "_in_ready"},  32'(ir),       32'd1);
      chk({tag, "_out_valid"}, 32'(ov_valid), 32'd0);
      chk({tag, "_fields"},    32'({d, bo, ov, z}), 32'd0);
   endtask

   // One operation on all three instances with out_ready held high.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv);
      logic [2:0] seen;
      int lat1, lat4, lat16;
      seen = 3'b000; lat1 = 0; lat4 = 0; lat16 = 0;
      set_in(1'b1, av, bv);
      @(negedge clk);
      // Operands after the acceptance edge must be ignored.
      set_in(1'b0, 16'($urandom), 16'($urandom));
      for (int c = 1; c <= 40 && seen != 3'b111; c++) begin
         @(negedge clk);
         if (c == 1) chk("busy_in_ready1", 32'(if1.in_ready), 32'd0);
         if (!seen[0] && if1.out_valid) begin
            seen[0] = 1'b1; lat1 = c;
            chk_out("d1", if1.diff, if1.borrow, if1.overflow, if1.zero, av, bv);
         end
         if (!seen[1] && if4.out_valid) begin
            seen[1] = 1'b1; lat4 = c;
            chk_out("d4", if4.diff, if4.borrow, if4.overflow, if4.zero, av, bv);
         end
         if (!seen[2] && if16.out_valid) begin
            seen[2] = 1'b1; lat16 = c;
            chk_out("d16", if16.diff, if16.borrow, if16.overflow, if16.zero, av, bv);
         end
      end
      chk("lat1",  32'(lat1),  32'd16);
      chk("lat4",  32'(lat4),  32'd4);
      chk("lat16", 32'(lat16), 32'd1);
      @(negedge clk);
      chk("ret_in_ready1",  32'(if1.in_ready),  32'd1);
      chk("ret_out_valid1", 32'(if1.out_valid), 32'd0);
   endtask

   logic [15:0] corner [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h8001};

   initial begin
      logic [15:0] ha, hb, ra, rb;
      logic [2:0]  hflags;
      bit          got_valid;

      set_in(1'b0, 16'h0000, 16'h0000);
      set_ordy(1'b1);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_rst("rst1",  if1.in_ready,  if1.out_valid,  if1.diff,  if1.borrow,  if1.overflow,  if1.zero);
      chk_rst("rst16", if16.in_ready, if16.out_valid, if16.diff, if16.borrow, if16.overflow, if16.zero);
      rst_n = 1'b1;

      // Directed cases
      run_op(16'd5,    16'd3);
      run_op(16'd3,    16'd5);
      run_op(16'h1234, 16'h1234);
      run_op(16'h8000, 16'h0001);
      run_op(16'h7FFF, 16'hFFFF);

      // Backpressure: result must hold while out_ready is low
      ha = 16'h9ABC; hb = 16'h1357;
      hflags = mdl_flags(ha, hb);
      set_ordy(1'b0);
      set_in(1'b1, ha, hb);
      @(negedge clk);
      set_in(1'b0, 16'h0000, 16'h0000);
      got_valid = 1'b0;
      for (int c = 0; c < 40 && !got_valid; c++) begin
         @(negedge clk);
         got_valid = if1.out_valid;
      end
      chk("bp_valid_seen", 32'(got_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         set_in(1'($urandom), 16'($urandom), 16'($urandom));
         @(negedge clk);
         chk("bp_diff",      32'(if1.diff), 32'(mdl_diff(ha, hb)));
         chk("bp_flags",     32'({if1.borrow, if1.overflow, if1.zero}), 32'(hflags));
         chk("bp_in_ready",  32'(if1.in_ready),  32'd0);
         chk("bp_out_valid", 32'(if1.out_valid), 32'd1);
      end
      set_in(1'b0, 16'h0000, 16'h0000);
      set_ordy(1'b1);
      @(negedge clk);
      chk("bp_release_valid", 32'(if1.out_valid), 32'd0);
      chk("bp_release_ready", 32'(if1.in_ready),  32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_no_second", 32'({if1.out_valid, if1.in_ready}), 32'b01);
      end

      // Reset in the middle of RUN: the aborted result never appears
      set_in(1'b1, 16'h4321, 16'h0F0F);
      @(negedge clk);
      set_in(1'b0, 16'h0000, 16'h0000);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_rst("mid1",  if1.in_ready,  if1.out_valid,  if1.diff,  if1.borrow,  if1.overflow,  if1.zero);
      chk_rst("mid4",  if4.in_ready,  if4.out_valid,  if4.diff,  if4.borrow,  if4.overflow,  if4.zero);
      chk_rst("mid16", if16.in_ready, if16.out_valid, if16.diff, if16.borrow, if16.overflow, if16.zero);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("mid_no_result", 32'(if1.out_valid), 32'd0);
      end
      run_op(16'hFFFF, 16'h0000);

      // Random regression
      for (int n = 0; n < 1000; n++) begin
         ra = (($urandom % 8) == 0) ? corner[$urandom % 6] : 16'($urandom);
         rb = (($urandom % 8) == 0) ? corner[$urandom % 6] : 16'($urandom);
         if (($urandom % 16) == 0) rb = ra;
         run_op(ra, rb);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
